// File: rtl/words_to_block_n.sv
// Packs a stream of WORD_W-bit words into N-lane blocks with a per-lane keep mask.
// A block closes when its last lane fills or when the incoming word carries word_last.
module words_to_block_n #(
  parameter int WORD_W    = 32,
  parameter int N         = 4,
  parameter bit MSW_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  word_valid,
  output logic                  word_ready,
  input  logic [WORD_W-1:0]     word,
  input  logic                  word_last,
  output logic                  block_valid,
  input  logic                  block_ready,
  output logic [N*WORD_W-1:0]   block,
  output logic [N-1:0]          block_keep,
  output logic                  block_last,
  output logic                  empty,
  output logic [15:0]           block_count
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N*WORD_W-1:0] block_q, block_d;
  logic [N-1:0]        keep_q, keep_d;
  logic                last_q, last_d;
  logic                valid_q, valid_d;
  logic [15:0]         count_q, count_d;

  logic word_acc;
  logic block_acc;
  logic closing;
  int   lane;

  assign word_ready = !valid_q | block_ready;
  assign word_acc   = word_valid & word_ready;
  assign block_acc  = valid_q & block_ready;
  assign closing    = word_acc & ((idx_q == LAST_IDX) | word_last);

  always_comb begin
    lane    = MSW_FIRST ? (N - 1 - int'(idx_q)) : int'(idx_q);
    idx_d   = idx_q;
    block_d = block_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q;
    count_d = count_q + 16'(block_acc);

    if (block_acc) begin
      valid_d = 1'b0;
    end

    if (word_acc) begin
      // Starting a new block wipes stale lanes so partial blocks read zero above the fill.
      if (idx_q == '0) begin
        block_d = '0;
        keep_d  = '0;
      end
      for (int l = 0; l < N; l++) begin
        if (l == lane) begin
          block_d[l*WORD_W +: WORD_W] = word;
          keep_d[l]                   = 1'b1;
        end
      end
      if (closing) begin
        idx_d   = '0;
        valid_d = 1'b1;
        last_d  = word_last;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      block_q <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      idx_q   <= idx_d;
      block_q <= block_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign block_valid = valid_q;
  assign block       = block_q;
  assign block_keep  = keep_q;
  assign block_last  = last_q;
  assign empty       = !valid_q & (idx_q == '0);
  assign block_count = count_q;

endmodule

// File: tb/tb_words_to_block_n.sv
// Directed table-driven bench: two instances (LSW-first and MSW-first lane order)
// share one stimulus stream; each step checks outputs before the edge that applies it.
module tb_words_to_block_n;

  typedef struct {
    logic         rst;
    logic         wv;
    logic [31:0]  w;
    logic         wl;
    logic         br;
    logic         ewr;
    logic         ebv;
    logic [127:0] eblk;
    logic [3:0]   ekeep;
    logic         elast;
    logic         eempty;
    logic [15:0]  ecnt;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         word_valid;
  logic [31:0]  word;
  logic         word_last;
  logic         block_ready;

  logic         wr0, bv0, bl0, em0;
  logic [127:0] blk0;
  logic [3:0]   keep0;
  logic [15:0]  cnt0;
  logic         wr1, bv1, bl1, em1;
  logic [127:0] blk1;
  logic [3:0]   keep1;
  logic [15:0]  cnt1;

  int checks = 0;
  int errors = 0;
  int stepNo = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  words_to_block_n #(.WORD_W(32), .N(4), .MSW_FIRST(1'b0)) dut_lsw (
    .clk(clk), .rst(rst), .word_valid(word_valid), .word_ready(wr0), .word(word),
    .word_last(word_last), .block_valid(bv0), .block_ready(block_ready), .block(blk0),
    .block_keep(keep0), .block_last(bl0), .empty(em0), .block_count(cnt0)
  );

  words_to_block_n #(.WORD_W(32), .N(4), .MSW_FIRST(1'b1)) dut_msw (
    .clk(clk), .rst(rst), .word_valid(word_valid), .word_ready(wr1), .word(word),
    .word_last(word_last), .block_valid(bv1), .block_ready(block_ready), .block(blk1),
    .block_keep(keep1), .block_last(bl1), .empty(em1), .block_count(cnt1)
  );

  function automatic vec_t mk(input logic r, wv, input logic [31:0] w, input logic wl, br,
                              input logic ewr, ebv, input logic [127:0] eblk,
                              input logic [3:0] ekeep, input logic elast, eempty,
                              input logic [15:0] ecnt);
    vec_t v;
    v.rst = r; v.wv = wv; v.w = w; v.wl = wl; v.br = br;
    v.ewr = ewr; v.ebv = ebv; v.eblk = eblk; v.ekeep = ekeep;
    v.elast = elast; v.eempty = eempty; v.ecnt = ecnt;
    return v;
  endfunction

  // With MSW_FIRST the k-th word lands in lane N-1-k, i.e. the lane order is mirrored.
  function automatic logic [127:0] revLanes(input logic [127:0] b);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[(3-i)*32 +: 32] = b[i*32 +: 32];
    return r;
  endfunction

  function automatic logic [3:0] revKeep(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  task automatic checkField(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, stepNo, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst         = v.rst;
    word_valid  = v.wv;
    word        = v.w;
    word_last   = v.wl;
    block_ready = v.br;
  endtask

  task automatic checkOutput(input vec_t v);
    checkField("word_ready",      128'(wr0),   128'(v.ewr));
    checkField("block_valid",     128'(bv0),   128'(v.ebv));
    checkField("block",           blk0,        v.eblk);
    checkField("block_keep",      128'(keep0), 128'(v.ekeep));
    if (v.ebv) checkField("block_last", 128'(bl0), 128'(v.elast));
    checkField("empty",           128'(em0),   128'(v.eempty));
    checkField("block_count",     128'(cnt0),  128'(v.ecnt));
    checkField("msw_word_ready",  128'(wr1),   128'(v.ewr));
    checkField("msw_block_valid", 128'(bv1),   128'(v.ebv));
    checkField("msw_block",       blk1,        revLanes(v.eblk));
    checkField("msw_block_keep",  128'(keep1), 128'(revKeep(v.ekeep)));
    checkField("msw_block_count", 128'(cnt1),  128'(v.ecnt));
  endtask

  task automatic runTable();
    foreach (tbl[i]) begin
      @(negedge clk);
      applyStimulus(tbl[i]);
      #1;
      checkOutput(tbl[i]);
      stepNo++;
    end
    tbl.delete();
  endtask

  initial begin
    // Reset with a word presented: nothing may be captured.
    rst = 1'b1; word_valid = 1'b1; word = 32'hDEADBEEF; word_last = 1'b1; block_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Four-word block, back to back, then consumed after one cycle.
    tbl.push_back(mk(0,1,32'h11111111,0,1, 1,0,128'h0,4'h0,0,1,16'd0));
    tbl.push_back(mk(0,1,32'h22222222,0,1, 1,0,128'h11111111,4'h1,0,0,16'd0));
    tbl.push_back(mk(0,1,32'h33333333,0,1, 1,0,128'h22222222_11111111,4'h3,0,0,16'd0));
    tbl.push_back(mk(0,1,32'h44444444,0,1, 1,0,128'h33333333_22222222_11111111,4'h7,0,0,16'd0));
    tbl.push_back(mk(0,0,32'h0,0,1, 1,1,128'h44444444_33333333_22222222_11111111,4'hF,0,0,16'd0));
    tbl.push_back(mk(0,0,32'h0,0,1, 1,0,128'h44444444_33333333_22222222_11111111,4'hF,0,1,16'd1));
    // Two-word packet closed early by word_last.
    tbl.push_back(mk(0,1,32'hAAAAAAAA,0,1, 1,0,128'h44444444_33333333_22222222_11111111,4'hF,0,1,16'd1));
    tbl.push_back(mk(0,1,32'hBBBBBBBB,1,1, 1,0,128'hAAAAAAAA,4'h1,0,0,16'd1));
    // Five stalled cycles with a word waiting: it must not be taken.
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,1,32'hCCCCCCCC,0,0, 0,1,128'hBBBBBBBB_AAAAAAAA,4'h3,1,0,16'd1));
    // Release: block consumed and the waiting word taken on the same edge.
    tbl.push_back(mk(0,1,32'hCCCCCCCC,0,1, 1,1,128'hBBBBBBBB_AAAAAAAA,4'h3,1,0,16'd1));
    tbl.push_back(mk(0,1,32'hDDDDDDDD,1,1, 1,0,128'hCCCCCCCC,4'h1,0,0,16'd2));
    // Eight single-word packets at full throughput.
    tbl.push_back(mk(0,1,32'h000000E0,1,1, 1,1,128'hDDDDDDDD_CCCCCCCC,4'h3,1,0,16'd2));
    for (int i = 1; i < 8; i++)
      tbl.push_back(mk(0,1,32'h000000E0 + 32'(i),1,1, 1,1,128'h000000E0 + 128'(i-1),4'h1,1,0,16'(2+i)));
    tbl.push_back(mk(0,0,32'h0,0,1, 1,1,128'h000000E7,4'h1,1,0,16'd10));
    tbl.push_back(mk(0,0,32'h0,0,1, 1,0,128'h000000E7,4'h1,1,1,16'd11));
    runTable();

    // Reset mid-block, then a fresh four-word block; word_last alone is ignored.
    tbl.push_back(mk(0,1,32'h55555555,0,1, 1,0,128'h000000E7,4'h1,0,1,16'd11));
    tbl.push_back(mk(0,1,32'h66666666,0,1, 1,0,128'h55555555,4'h1,0,0,16'd11));
    tbl.push_back(mk(1,1,32'h77777777,1,1, 1,0,128'h66666666_55555555,4'h3,0,0,16'd11));
    tbl.push_back(mk(0,0,32'h0,1,1, 1,0,128'h0,4'h0,0,1,16'd0));
    tbl.push_back(mk(0,1,32'h00000001,0,1, 1,0,128'h0,4'h0,0,1,16'd0));
    tbl.push_back(mk(0,1,32'h00000002,0,1, 1,0,128'h00000001,4'h1,0,0,16'd0));
    tbl.push_back(mk(0,1,32'h00000003,0,1, 1,0,128'h00000002_00000001,4'h3,0,0,16'd0));
    tbl.push_back(mk(0,1,32'h00000004,0,1, 1,0,128'h00000003_00000002_00000001,4'h7,0,0,16'd0));
    tbl.push_back(mk(0,0,32'h0,0,1, 1,1,128'h00000004_00000003_00000002_00000001,4'hF,0,0,16'd0));
    tbl.push_back(mk(0,0,32'h0,0,1, 1,0,128'h00000004_00000003_00000002_00000001,4'hF,0,1,16'd1));
    runTable();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/words_to_block_n.md
WORDS_TO_BLOCK_N -- requirements
Module: words_to_block_n

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning width of one input word in bits (≥1).
REQ-002 SHALL have parameter N, default 4, meaning words per output block (≥2).
REQ-003 SHALL have parameter MSW_FIRST, default 0, meaning lane order: 0 = first word in lowest lane, 1 = first word in highest lane.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 SHALL have port word_valid, input, 1, meaning the upstream word is valid.
REQ-007 SHALL have port word_ready, output, 1, meaning the block accepts a word this cycle.
REQ-008 SHALL have port word, input, WORD_W, meaning input word data.
REQ-009 SHALL have port word_last, input, 1, meaning this word ends a packet; the block closes early.
REQ-010 SHALL have port block_valid, output, 1, meaning the output block is valid.
REQ-011 SHALL have port block_ready, input, 1, meaning downstream accepts the block.
REQ-012 SHALL have port block, output, N*WORD_W, meaning assembled block data.
REQ-013 SHALL have port block_keep, output, N, meaning per-lane valid mask.
REQ-014 SHALL have port block_last, output, 1, meaning the block ends a packet.
REQ-015 SHALL have port empty, output, 1, meaning no word is held and no block is pending.
REQ-016 SHALL have port block_count, output, 16, meaning the number of blocks consumed downstream.

Function
REQ-017 SHALL define transfers only as valid&ready on the same edge: word accept = word_valid&word_ready; block accept = block_valid&block_ready.
REQ-018 SHALL drive word_ready = !block_valid | block_ready, combinationally, with no dependence on word_valid.
REQ-019 SHALL track the fill index idx, range 0..N-1, width $clog2(N), as the lane count of the block being assembled.
REQ-020 SHALL map the word accepted at index k to lane L: L = k when MSW_FIRST=0, L = N-1-k when MSW_FIRST=1. Lane L occupies block bits [L*WORD_W +: WORD_W].
REQ-021 SHALL, on a word accept at idx=0, clear all lanes and all keep bits to 0, then write the word to its lane and set that lane's keep bit.
REQ-022 SHALL, on a word accept at idx>0, write only the addressed lane and keep bit; all other lanes hold.
REQ-023 SHALL close the block on a word accept with idx=N-1 or word_last=1. Closing sets block_valid=1 and idx=0 on the next edge, and block_last is set to that word's word_last.
REQ-024 SHALL otherwise, on a word accept, increment idx with no wrap (idx<N-1 guaranteed by REQ-023).
REQ-025 SHALL set latency as follows: block_valid rises on the edge that accepts the closing word, so the block is visible one cycle after that word is presented.
REQ-026 SHALL, on a block accept with no closing word accept on the same edge, clear block_valid to 0.
REQ-027 SHALL, on a block accept and a closing word accept on the same edge, keep block_valid=1 with the new block contents; a single-word packet with word_last=1 gives sustained full throughput.
REQ-028 SHALL, on a block accept and a non-closing word accept on the same edge (idx=0), clear block_valid, clear lanes per REQ-021, and set idx=1.
REQ-029 SHALL keep block, block_keep and block_last stable while block_valid=1 and block_ready=0.
REQ-030 SHALL give a closed block of a full block_keep all ones; a partial block has keep bits only for filled lanes and unfilled lanes read as zero.
REQ-031 SHALL increment block_count by 1 on each block accept, wrapping 16'hFFFF→0.
REQ-032 SHALL drive empty = !block_valid & (idx==0).
REQ-033 SHALL make a word_last asserted without word_valid have no effect.

Reset
REQ-034 SHALL, on rst=1 at a clock edge, set idx=0, block_valid=0, block_keep=0, block_last=0, block=0 and block_count=0. Any partial block is discarded.
REQ-035 SHALL give reset priority over all simultaneous transfers; during rst=1, word_ready follows REQ-018 but no accepted word is stored.
REQ-036 SHALL leave empty=1 and word_ready=1 in the cycle after reset is released.

Verification
REQ-037 SHALL cover this scenario: WORD_W=32, N=4, MSW_FIRST=0, words 0x11111111..0x44444444 back-to-back, block_ready=1 → block=0x44444444_33333333_22222222_11111111, keep=4'hF, last=0, valid for 1 cycle, block_count=1.
REQ-038 SHALL cover this scenario: same stimulus with MSW_FIRST=1 → block=0x11111111_22222222_33333333_44444444.
REQ-039 SHALL cover this scenario: 0xAAAAAAAA then 0xBBBBBBBB with word_last=1 → block=0x00000000_00000000_BBBBBBBB_AAAAAAAA, keep=4'h3, last=1.
REQ-040 SHALL cover this scenario: block_ready=0 for 5 cycles after a block closes → word_ready=0, block stable for 5 cycles; on release the next word is accepted on the same edge (REQ-028).
REQ-041 SHALL cover this scenario: 8 consecutive single-word packets (word_last=1), block_ready=1 → 8 blocks on 8 consecutive cycles with keep=4'h1, block_count=8.
REQ-042 SHALL cover this scenario: rst pulsed after 2 of 4 words, then 4 new words → first block contains only the new words, keep=4'hF, block_count=1.
